// File: rtl/i2c_cmd_pkg.sv
// Shared encodings for the I2C command decoder:
// FSM states, status-byte bit positions and channel limits.
package i2c_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_STAT = 3'd1,
        ST_D1   = 3'd2,
        ST_D2   = 3'd3,
        ST_D3   = 3'd4
    } state_t;

    localparam int STAT_PWM_ON  = 0;
    localparam int STAT_ONESHOT = 1;
    localparam int STAT_TYPE    = 7;

    localparam logic [7:0] CH_MAX = 8'h7F;
    localparam int         NUM_CH = 4;

    function automatic logic in_data(state_t s);
        return (s == ST_D1) || (s == ST_D2) || (s == ST_D3);
    endfunction

endpackage

// File: rtl/i2c_cmd_decoder_sync_edge.sv
// Two-flop synchroniser with a history flop for edge detection.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d_in,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic s1_q, s2_q, h_q;
    logic s1_d, s2_d, h_d;

    always_comb begin
        s1_d = d_in;
        s2_d = s1_q;
        h_d  = s2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            h_q  <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            h_q  <= h_d;
        end
    end

    assign lvl  = s2_q;
    assign rise = s2_q & ~h_q;
    assign fall = ~s2_q & h_q;

endmodule

// File: rtl/i2c_cmd_decoder.sv
// Parses status + 4 channel byte frames from the I2C slave and
// commits them atomically to the PWM generator, with a watchdog.
module i2c_cmd_decoder
    import i2c_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYC = 208000,
    parameter int TMR_W       = 18
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       data_vld_in,
    input  logic [7:0] data_in,
    input  logic       start_in,
    input  logic       stop_in,
    input  logic       r_w_in,
    output logic [7:0] status_out,
    output logic [7:0] ch0_out,
    output logic [7:0] ch1_out,
    output logic [7:0] ch2_out,
    output logic [7:0] ch3_out,
    output logic       one_shot_req,
    output logic       frame_done,
    output logic       frame_err,
    output logic       failsafe
);

    localparam logic [TMR_W-1:0] TMO = TMR_W'(TIMEOUT_CYC);

    logic byte_ev, start_ev, stop_ev, rw_lvl;
    logic vld_lvl_unused, vld_rise_unused;
    logic start_lvl_unused, start_fall_unused;
    logic stop_lvl_unused, stop_fall_unused;
    logic rw_rise_unused, rw_fall_unused;

    sync_edge u_vld (
        .clk   (clk),
        .rst_n (rst_n),
        .d_in  (data_vld_in),
        .lvl   (vld_lvl_unused),
        .rise  (vld_rise_unused),
        .fall  (byte_ev)
    );

    sync_edge u_start (
        .clk   (clk),
        .rst_n (rst_n),
        .d_in  (start_in),
        .lvl   (start_lvl_unused),
        .rise  (start_ev),
        .fall  (start_fall_unused)
    );

    sync_edge u_stop (
        .clk   (clk),
        .rst_n (rst_n),
        .d_in  (stop_in),
        .lvl   (stop_lvl_unused),
        .rise  (stop_ev),
        .fall  (stop_fall_unused)
    );

    sync_edge u_rw (
        .clk   (clk),
        .rst_n (rst_n),
        .d_in  (r_w_in),
        .lvl   (rw_lvl),
        .rise  (rw_rise_unused),
        .fall  (rw_fall_unused)
    );

    // Data is stable around vld, so plain two-stage capture suffices.
    logic [7:0] data_s1_q, data_s2_q;
    logic [7:0] data_s1_d, data_s2_d;

    state_t                  state_q, state_d;
    logic [7:0]              sh_stat_q, sh_stat_d;
    logic [NUM_CH-1:0][7:0]  sh_ch_q, sh_ch_d;
    logic [7:0]              status_q, status_d;
    logic [NUM_CH-1:0][7:0]  ch_q, ch_d;
    logic                    fs_q, fs_d;
    logic [TMR_W-1:0]        wd_q, wd_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic                    os_q, os_d;

    logic commit_full, commit_stat, commit, expired;

    always_comb begin
        data_s1_d = data_in;
        data_s2_d = data_s1_q;
    end

    always_comb begin
        state_d     = state_q;
        sh_stat_d   = sh_stat_q;
        sh_ch_d     = sh_ch_q;
        status_d    = status_q;
        ch_d        = ch_q;
        fs_d        = fs_q;
        wd_d        = wd_q;
        err_d       = 1'b0;
        done_d      = 1'b0;
        os_d        = 1'b0;
        commit_full = 1'b0;
        commit_stat = 1'b0;
        commit      = 1'b0;
        expired     = (wd_q == TMO);

        // Byte first; stop/start then act on the resulting state.
        if (byte_ev && !rw_lvl) begin
            if (data_s2_q[STAT_TYPE]) begin
                sh_stat_d = data_s2_q;
                err_d     = in_data(state_d);
                state_d   = ST_STAT;
            end else begin
                case (state_d)
                    ST_IDLE: err_d = 1'b1;
                    ST_STAT: begin
                        sh_ch_d[0] = data_s2_q & CH_MAX;
                        state_d    = ST_D1;
                    end
                    ST_D1: begin
                        sh_ch_d[1] = data_s2_q & CH_MAX;
                        state_d    = ST_D2;
                    end
                    ST_D2: begin
                        sh_ch_d[2] = data_s2_q & CH_MAX;
                        state_d    = ST_D3;
                    end
                    ST_D3: begin
                        sh_ch_d[3]  = data_s2_q & CH_MAX;
                        commit_full = 1'b1;
                        state_d     = ST_IDLE;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end

        if (stop_ev) begin
            if (state_d == ST_STAT) begin
                commit_stat = 1'b1;
                state_d     = ST_IDLE;
            end else if (in_data(state_d)) begin
                err_d   = 1'b1;
                state_d = ST_IDLE;
            end
        end

        if (start_ev) begin
            if (state_d == ST_STAT) begin
                state_d = ST_IDLE;
            end else if (in_data(state_d)) begin
                err_d   = 1'b1;
                state_d = ST_IDLE;
            end
        end

        commit = commit_full | commit_stat;

        if (commit) begin
            status_d = sh_stat_d;
            if (commit_full) begin
                ch_d = sh_ch_d;
            end
            done_d = 1'b1;
            os_d   = sh_stat_d[STAT_ONESHOT];
            fs_d   = 1'b0;
            wd_d   = '0;
        end else if (expired) begin
            fs_d                  = 1'b1;
            status_d[STAT_PWM_ON] = 1'b0;
            ch_d                  = '0;
        end else begin
            wd_d = wd_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_s1_q <= '0;
            data_s2_q <= '0;
            state_q   <= ST_IDLE;
            sh_stat_q <= '0;
            sh_ch_q   <= '0;
            status_q  <= '0;
            ch_q      <= '0;
            fs_q      <= 1'b1;
            wd_q      <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            os_q      <= 1'b0;
        end else begin
            data_s1_q <= data_s1_d;
            data_s2_q <= data_s2_d;
            state_q   <= state_d;
            sh_stat_q <= sh_stat_d;
            sh_ch_q   <= sh_ch_d;
            status_q  <= status_d;
            ch_q      <= ch_d;
            fs_q      <= fs_d;
            wd_q      <= wd_d;
            done_q    <= done_d;
            err_q     <= err_d;
            os_q      <= os_d;
        end
    end

    assign status_out   = status_q;
    assign ch0_out      = ch_q[0];
    assign ch1_out      = ch_q[1];
    assign ch2_out      = ch_q[2];
    assign ch3_out      = ch_q[3];
    assign one_shot_req = os_q;
    assign frame_done   = done_q;
    assign frame_err    = err_q;
    assign failsafe     = fs_q;

endmodule

// File: tb/tb_i2c_cmd_decoder.sv
// Directed, table-driven bench for the I2C command decoder.
module tb_i2c_cmd_decoder;

    localparam int TMO = 400;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       data_vld_in = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       start_in = 1'b0;
    logic       stop_in = 1'b0;
    logic       r_w_in = 1'b0;
    logic [7:0] status_out, ch0_out, ch1_out, ch2_out, ch3_out;
    logic       one_shot_req, frame_done, frame_err, failsafe;

    i2c_cmd_decoder #(.TIMEOUT_CYC(TMO), .TMR_W(18)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_vld_in  (data_vld_in),
        .data_in      (data_in),
        .start_in     (start_in),
        .stop_in      (stop_in),
        .r_w_in       (r_w_in),
        .status_out   (status_out),
        .ch0_out      (ch0_out),
        .ch1_out      (ch1_out),
        .ch2_out      (ch2_out),
        .ch3_out      (ch3_out),
        .one_shot_req (one_shot_req),
        .frame_done   (frame_done),
        .frame_err    (frame_err),
        .failsafe     (failsafe)
    );

    always #5 clk = ~clk;

    int n_done = 0, n_err = 0, n_os = 0;
    int tests = 0, fails = 0;

    always @(negedge clk) begin
        n_done += int'(frame_done);
        n_err  += int'(frame_err);
        n_os   += int'(one_shot_req);
    end

    localparam int K_BYTE  = 0;
    localparam int K_STOP  = 1;
    localparam int K_START = 2;

    typedef struct {
        int          kind;
        logic [7:0]  dat;
        logic        rw;
        logic [7:0]  st;
        logic [31:0] ch;
        logic        fs;
        int          d;
        int          e;
        int          o;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(int kind, logic [7:0] dat, logic rw,
                                logic [7:0] st, logic [31:0] ch, logic fs,
                                int d, int e, int o);
        vec_t v;
        v.kind = kind; v.dat = dat; v.rw = rw;
        v.st = st; v.ch = ch; v.fs = fs;
        v.d = d; v.e = e; v.o = o;
        return v;
    endfunction

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    task automatic check_outs(string tag, logic [7:0] st, logic [31:0] ch,
                              logic fs);
        check({tag, " status"}, 32'(status_out), 32'(st));
        check({tag, " ch"}, {ch0_out, ch1_out, ch2_out, ch3_out}, ch);
        check({tag, " failsafe"}, 32'(failsafe), 32'(fs));
    endtask

    task automatic send_byte(logic [7:0] b, logic rw);
        r_w_in  = rw;
        data_in = b;
        cyc(2);
        data_vld_in = 1'b1;
        cyc(3);
        data_vld_in = 1'b0;
        cyc(6);
    endtask

    task automatic pulse_stop();
        stop_in = 1'b1;
        cyc(3);
        stop_in = 1'b0;
        cyc(6);
    endtask

    task automatic pulse_start();
        start_in = 1'b1;
        cyc(3);
        start_in = 1'b0;
        cyc(6);
    endtask

    task automatic run_step(string tag, vec_t v);
        int d0, e0, o0;
        d0 = n_done; e0 = n_err; o0 = n_os;
        case (v.kind)
            K_BYTE:  send_byte(v.dat, v.rw);
            K_STOP:  pulse_stop();
            default: pulse_start();
        endcase
        check_outs(tag, v.st, v.ch, v.fs);
        check({tag, " done"}, 32'(n_done - d0), 32'(v.d));
        check({tag, " err"}, 32'(n_err - e0), 32'(v.e));
        check({tag, " oneshot"}, 32'(n_os - o0), 32'(v.o));
    endtask

    initial begin
        int d0, e0;
        // full frame
        tv.push_back(mk(K_BYTE, 8'h81, 0, 8'h00, 32'h00000000, 1, 0, 0, 0));
        tv.push_back(mk(K_BYTE, 8'h10, 0, 8'h00, 32'h00000000, 1, 0, 0, 0));
        tv.push_back(mk(K_BYTE, 8'h20, 0, 8'h00, 32'h00000000, 1, 0, 0, 0));
        tv.push_back(mk(K_BYTE, 8'h30, 0, 8'h00, 32'h00000000, 1, 0, 0, 0));
        tv.push_back(mk(K_BYTE, 8'h7F, 0, 8'h81, 32'h1020307F, 0, 1, 0, 0));
        tv.push_back(mk(K_STOP, 8'h00, 0, 8'h81, 32'h1020307F, 0, 0, 0, 0));
        // one-shot, then status-only
        tv.push_back(mk(K_BYTE, 8'h83, 0, 8'h81, 32'h1020307F, 0, 0, 0, 0));
        tv.push_back(mk(K_BYTE, 8'h01, 0, 8'h81, 32'h1020307F, 0, 0, 0, 0));
        tv.push_back(mk(K_BYTE, 8'h02, 0, 8'h81, 32'h1020307F, 0, 0, 0, 0));
        tv.push_back(mk(K_BYTE, 8'h03, 0, 8'h81, 32'h1020307F, 0, 0, 0, 0));
        tv.push_back(mk(K_BYTE, 8'h04, 0, 8'h83, 32'h01020304, 0, 1, 0, 1));
        tv.push_back(mk(K_BYTE, 8'h80, 0, 8'h83, 32'h01020304, 0, 0, 0, 0));
        tv.push_back(mk(K_STOP, 8'h00, 0, 8'h80, 32'h01020304, 0, 1, 0, 0));
        // truncated frame, then a full one
        tv.push_back(mk(K_BYTE, 8'h81, 0, 8'h80, 32'h01020304, 0, 0, 0, 0));
        tv.push_back(mk(K_BYTE, 8'h05, 0, 8'h80, 32'h01020304, 0, 0, 0, 0));
        tv.push_back(mk(K_STOP, 8'h00, 0, 8'h80, 32'h01020304, 0, 0, 1, 0));
        tv.push_back(mk(K_BYTE, 8'h81, 0, 8'h80, 32'h01020304, 0, 0, 0, 0));
        tv.push_back(mk(K_BYTE, 8'h0A, 0, 8'h80, 32'h01020304, 0, 0, 0, 0));
        tv.push_back(mk(K_BYTE, 8'h0B, 0, 8'h80, 32'h01020304, 0, 0, 0, 0));
        tv.push_back(mk(K_BYTE, 8'h0C, 0, 8'h80, 32'h01020304, 0, 0, 0, 0));
        tv.push_back(mk(K_BYTE, 8'h0D, 0, 8'h81, 32'h0A0B0C0D, 0, 1, 0, 0));
        // resync on new status byte
        tv.push_back(mk(K_BYTE, 8'h81, 0, 8'h81, 32'h0A0B0C0D, 0, 0, 0, 0));
        tv.push_back(mk(K_BYTE, 8'h11, 0, 8'h81, 32'h0A0B0C0D, 0, 0, 0, 0));
        tv.push_back(mk(K_BYTE, 8'h22, 0, 8'h81, 32'h0A0B0C0D, 0, 0, 0, 0));
        tv.push_back(mk(K_BYTE, 8'h81, 0, 8'h81, 32'h0A0B0C0D, 0, 0, 1, 0));
        tv.push_back(mk(K_BYTE, 8'h01, 0, 8'h81, 32'h0A0B0C0D, 0, 0, 0, 0));
        tv.push_back(mk(K_BYTE, 8'h02, 0, 8'h81, 32'h0A0B0C0D, 0, 0, 0, 0));
        tv.push_back(mk(K_BYTE, 8'h03, 0, 8'h81, 32'h0A0B0C0D, 0, 0, 0, 0));
        tv.push_back(mk(K_BYTE, 8'h04, 0, 8'h81, 32'h01020304, 0, 1, 0, 0));
        // stray data in IDLE
        tv.push_back(mk(K_BYTE, 8'h40, 0, 8'h81, 32'h01020304, 0, 0, 1, 0));
        // repeated start in D1 and in STAT
        tv.push_back(mk(K_BYTE, 8'h81, 0, 8'h81, 32'h01020304, 0, 0, 0, 0));
        tv.push_back(mk(K_BYTE, 8'h05, 0, 8'h81, 32'h01020304, 0, 0, 0, 0));
        tv.push_back(mk(K_START, 8'h00, 0, 8'h81, 32'h01020304, 0, 0, 1, 0));
        tv.push_back(mk(K_BYTE, 8'h81, 0, 8'h81, 32'h01020304, 0, 0, 0, 0));
        tv.push_back(mk(K_START, 8'h00, 0, 8'h81, 32'h01020304, 0, 0, 0, 0));
        tv.push_back(mk(K_BYTE, 8'h06, 0, 8'h81, 32'h01020304, 0, 0, 1, 0));
        // master reads are ignored
        tv.push_back(mk(K_BYTE, 8'h81, 1, 8'h81, 32'h01020304, 0, 0, 0, 0));
        tv.push_back(mk(K_BYTE, 8'h06, 1, 8'h81, 32'h01020304, 0, 0, 0, 0));
        // frame before watchdog test
        tv.push_back(mk(K_BYTE, 8'h81, 0, 8'h81, 32'h01020304, 0, 0, 0, 0));
        tv.push_back(mk(K_BYTE, 8'h50, 0, 8'h81, 32'h01020304, 0, 0, 0, 0));
        tv.push_back(mk(K_BYTE, 8'h50, 0, 8'h81, 32'h01020304, 0, 0, 0, 0));
        tv.push_back(mk(K_BYTE, 8'h50, 0, 8'h81, 32'h01020304, 0, 0, 0, 0));
        tv.push_back(mk(K_BYTE, 8'h50, 0, 8'h81, 32'h50505050, 0, 1, 0, 0));

        cyc(3);
        check_outs("reset", 8'h00, 32'h0, 1'b1);
        check("reset pulses", {29'd0, frame_done, frame_err, one_shot_req},
              32'h0);
        rst_n = 1'b1;
        cyc(3);

        for (int i = 0; i < tv.size(); i++)
            run_step($sformatf("step%0d", i), tv[i]);

        // watchdog: just before and just after expiry
        cyc(TMO - 20);
        check_outs("wd_pre", 8'h81, 32'h50505050, 1'b0);
        cyc(40);
        check_outs("wd_post", 8'h80, 32'h00000000, 1'b1);
        run_step("wd_r0", mk(K_BYTE, 8'h81, 0, 8'h80, 32'h0, 1, 0, 0, 0));
        run_step("wd_r1", mk(K_BYTE, 8'h7F, 0, 8'h80, 32'h0, 1, 0, 0, 0));
        run_step("wd_r2", mk(K_BYTE, 8'h00, 0, 8'h80, 32'h0, 1, 0, 0, 0));
        run_step("wd_r3", mk(K_BYTE, 8'h12, 0, 8'h80, 32'h0, 1, 0, 0, 0));
        run_step("wd_r4", mk(K_BYTE, 8'h34, 0, 8'h81, 32'h7F001234, 0, 1, 0, 0));

        // last data byte and stop land in the same cycle
        send_byte(8'h81, 1'b0);
        send_byte(8'h21, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h23, 1'b0);
        d0 = n_done; e0 = n_err;
        data_in = 8'h24;
        cyc(2);
        data_vld_in = 1'b1;
        cyc(3);
        data_vld_in = 1'b0;
        stop_in = 1'b1;
        cyc(3);
        stop_in = 1'b0;
        cyc(6);
        check_outs("same_cyc", 8'h81, 32'h21222324, 1'b0);
        check("same_cyc done", 32'(n_done - d0), 32'd1);
        check("same_cyc err", 32'(n_err - e0), 32'd0);

        // reset between byte 2 and byte 3
        send_byte(8'h83, 1'b0);
        send_byte(8'h31, 1'b0);
        d0 = n_done; e0 = n_err;
        rst_n = 1'b0;
        cyc(4);
        check_outs("mid_rst", 8'h00, 32'h0, 1'b1);
        rst_n = 1'b1;
        cyc(2);
        send_byte(8'h32, 1'b0);
        check("mid_rst err", 32'(n_err - e0), 32'd1);
        check("mid_rst done", 32'(n_done - d0), 32'd0);
        check_outs("post_rst0", 8'h00, 32'h0, 1'b1);
        run_step("post_rst1", mk(K_BYTE, 8'h81, 0, 8'h00, 32'h0, 1, 0, 0, 0));
        run_step("post_rst2", mk(K_BYTE, 8'h01, 0, 8'h00, 32'h0, 1, 0, 0, 0));
        run_step("post_rst3", mk(K_BYTE, 8'h02, 0, 8'h00, 32'h0, 1, 0, 0, 0));
        run_step("post_rst4", mk(K_BYTE, 8'h03, 0, 8'h00, 32'h0, 1, 0, 0, 0));
        run_step("post_rst5", mk(K_BYTE, 8'h04, 0, 8'h81, 32'h01020304, 0, 1, 0, 0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
